alu_seq: RTL and testbench
==========================

# alu_seq

Registered, handshaked ALU for the single-cycle processor datapath, parametrised in operand width. It keeps the existing 5-bit function encoding and adds compare, shifts and an iterative multiplier. It also adds a flag output and valid/ready flow control on both the operand side and the result side. It sits between the register-read/immediate mux stage and writeback; branch logic consumes `flags` and the compare result.

## Interface
- `WIDTH`, 32, operand/result width; even, ≥ 8.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `func`  in  5  operation code; sampled at accept.
- `dataIn1`  in  WIDTH  operand A; sampled at accept.
- `dataIn2`  in  WIDTH  operand B or immediate; sampled at accept.
- `inValid`  in  1  operands and `func` valid.
- `inReady`  out  1  block can accept this cycle.
- `dataOut`  out  WIDTH  result.
- `flags`  out  4  {N, Z, C, V} for the result.
- `illegal`  out  1  result came from an unsupported `func`.
- `outValid`  out  1  `dataOut`, `flags` and `illegal` valid.
- `outReady`  in  1  consumer takes the result.
- `busy`  out  1  multiply in progress.

## Operation
- Accept occurs when `inValid && inReady`. Transfer out occurs when `outValid && outReady`.
- `inReady` = (state == IDLE) && (!outValid || outReady). This allows accept in the same cycle as drain.
- Func encodings:
  - 00000 ADD: A+B.
  - 00001 SUB: A−B.
  - 00010 CMP: dataOut = signed(A) < signed(B) ? 1 : 0. Flags are those of A−B.
  - 00011 MUL: low WIDTH bits of unsigned A×B.
  - 00100 AND, 00101 OR, 00110 XOR.
  - 01100 NAND, 01101 NOR, 01110 XNOR.
  - 01000 SLL, 01001 SRL, 01010 SRA: shift A by B[$clog2(WIDTH)-1:0].
  - 01011 MVHI: B with the low WIDTH/2 bits cleared.
  - Any other code: dataOut = 0, flags = 0, `illegal` = 1.
- Flags:
  - N = dataOut[WIDTH-1]; Z = (dataOut == 0).
  - ADD: C = carry out. SUB/CMP: C = carry out of A + ~B + 1, so C = 1 means no borrow. V = signed overflow.
  - CMP: N and Z come from A−B, not from dataOut.
  - MUL: C = V = (upper WIDTH bits of the product ≠ 0).
  - Logic, shift and MVHI ops: C = V = 0.
- States:
  - IDLE: accepting. A non-MUL accept loads the output register directly and stays in IDLE. A MUL accept latches the operands, clears the accumulator, sets count = 0 and moves to MUL.
  - MUL: shift-add, one multiplier bit per cycle, LSB first, with a 2·WIDTH-bit accumulator. `busy` = 1. After the WIDTH-th iteration, load the output register and return to IDLE.
- Output register: holds `dataOut`, `flags` and `illegal` stable while `outValid && !outReady`. `outValid` clears on transfer unless a new result loads in the same cycle.
- MUL completion with `outValid` still set cannot occur: MUL is entered only when the output slot is free or draining.

## Timing
- Reset values:
  - `dataOut` = 0, `flags` = 0, `illegal` = 0, `outValid` = 0, `busy` = 0.
  - State = IDLE, so `inReady` = 1.
- Non-MUL latency: accept at cycle N gives `outValid` = 1 in cycle N+1. Throughput is 1 per cycle while `outReady` = 1.
- MUL latency: accept at cycle N gives `busy` = 1 in cycles N+1..N+WIDTH and `outValid` = 1 in cycle N+WIDTH+1. `inReady` = 0 during MUL.
- Reset asserted mid-MUL or with a result pending: all state clears immediately, the pending result is discarded, and no `outValid` pulse follows the release of reset.
- `inValid` asserted while `inReady` = 0: ignored. The source must hold its operands until accept.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL (00011) is implemented as above, including the MUL state, counter and accumulator.
- Not defined: no multiplier logic is present. 00011 is treated as illegal: 1-cycle latency, dataOut = 0, `illegal` = 1. `busy` is tied to 0.

## Test plan
- ADD with WIDTH=32, A=0xFFFFFFFF, B=1 → dataOut = 0, flags N=0 Z=1 C=1 V=0, `outValid` one cycle after accept.
- CMP A=5, B=7 → dataOut = 1, N=1 Z=0 C=0 V=0. SUB A=0x80000000, B=1 → dataOut = 0x7FFFFFFF, V=1, C=1.
- MUL A=0x00010000, B=0x00010000 with `ALU_SEQ_MUL_EN` → dataOut = 0, C=V=1, `outValid` 33 cycles after accept, `inReady` = 0 throughout. Also A=3, B=5 → 15.
- Backpressure: back-to-back XOR ops with `outReady` = 0 for 5 cycles → first result held stable, `inReady` = 0. On release, results drain in order, one per cycle.
- Reset: assert `reset_n` = 0 in cycle 10 of a MUL → `busy` and `outValid` drop asynchronously, and no result appears after release.
- Illegal func 11111, and 00011 built without the macro → dataOut = 0, `illegal` = 1, 1-cycle latency. SRA A=0x80000000, B=4 → 0xF8000000.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready on both sides and {N,Z,C,V} flags.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (func 00011).
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       func,
    input  logic [WIDTH-1:0] dataIn1,
    input  logic [WIDTH-1:0] dataIn2,
    input  logic             inValid,
    output logic             inReady,
    output logic [WIDTH-1:0] dataOut,
    output logic [3:0]       flags,
    output logic             illegal,
    output logic             outValid,
    input  logic             outReady,
    output logic             busy
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int HALF = WIDTH / 2;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [SHW-1:0]   shamt;
    logic             add_v;
    logic             sub_v;
    logic             lt;
    logic [WIDTH-1:0] res_data;
    logic [3:0]       res_flags;
    logic             res_illegal;
    logic             res_c;
    logic             res_v;

    assign sum_ext  = {1'b0, dataIn1} + {1'b0, dataIn2};
    assign diff_ext = {1'b0, dataIn1} + {1'b0, ~dataIn2} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt    = dataIn2[SHW-1:0];
    assign add_v    = (dataIn1[WIDTH-1] == dataIn2[WIDTH-1]) && (sum_ext[WIDTH-1] != dataIn1[WIDTH-1]);
    assign sub_v    = (dataIn1[WIDTH-1] != dataIn2[WIDTH-1]) && (diff_ext[WIDTH-1] != dataIn1[WIDTH-1]);
    // Signed A < B is the sign of the exact difference, i.e. N xor V.
    assign lt       = diff_ext[WIDTH-1] ^ sub_v;

    always_comb begin
        res_data    = '0;
        res_illegal = 1'b0;
        res_c       = 1'b0;
        res_v       = 1'b0;
        case (func)
            5'b00000: begin
                res_data = sum_ext[WIDTH-1:0];
                res_c    = sum_ext[WIDTH];
                res_v    = add_v;
            end
            5'b00001: begin
                res_data = diff_ext[WIDTH-1:0];
                res_c    = diff_ext[WIDTH];
                res_v    = sub_v;
            end
            5'b00010: begin
                res_data = {{(WIDTH-1){1'b0}}, lt};
                res_c    = diff_ext[WIDTH];
                res_v    = sub_v;
            end
            5'b00100: res_data = dataIn1 & dataIn2;
            5'b00101: res_data = dataIn1 | dataIn2;
            5'b00110: res_data = dataIn1 ^ dataIn2;
            5'b01100: res_data = ~(dataIn1 & dataIn2);
            5'b01101: res_data = ~(dataIn1 | dataIn2);
            5'b01110: res_data = ~(dataIn1 ^ dataIn2);
            5'b01000: res_data = dataIn1 << shamt;
            5'b01001: res_data = dataIn1 >> shamt;
            5'b01010: res_data = WIDTH'($signed(dataIn1) >>> shamt);
            5'b01011: res_data = {dataIn2[WIDTH-1:HALF], {HALF{1'b0}}};
            default:  res_illegal = 1'b1;
        endcase
        res_flags = {res_data[WIDTH-1], res_data == '0, res_c, res_v};
        if (func == 5'b00010) begin
            res_flags[3:2] = {diff_ext[WIDTH-1], diff_ext[WIDTH-1:0] == '0};
        end
        if (res_illegal) begin
            res_flags = '0;
        end
    end

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [3:0]       flags_q, flags_d;
    logic             illegal_q, illegal_d;
    logic             accept;
    logic             load_alu;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;
    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     count_q, count_d;

    assign inReady  = (state_q == IDLE) && (!out_valid_q || outReady);
    assign busy     = (state_q == MUL);
    assign accept   = inValid && inReady;
    assign load_alu = accept && (func != 5'b00011);
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
    assign inReady  = !out_valid_q || outReady;
    assign busy     = 1'b0;
    assign accept   = inValid && inReady;
    assign load_alu = accept;
`endif

    always_comb begin
        out_valid_d = out_valid_q && !outReady;
        data_d      = data_q;
        flags_d     = flags_q;
        illegal_d   = illegal_q;
        if (load_alu) begin
            out_valid_d = 1'b1;
            data_d      = res_data;
            flags_d     = res_flags;
            illegal_d   = res_illegal;
        end
`ifdef ALU_SEQ_MUL_EN
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (accept && (func == 5'b00011)) begin
                    mcand_d  = {{WIDTH{1'b0}}, dataIn1};
                    mplier_d = dataIn2;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = MUL;
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                // The output slot is known free here: MUL was entered only with it free or draining.
                if (count_q == SHW'(WIDTH - 1)) begin
                    out_valid_d = 1'b1;
                    data_d      = acc_step[WIDTH-1:0];
                    flags_d     = {acc_step[WIDTH-1], acc_step[WIDTH-1:0] == '0,
                                   |acc_step[2*WIDTH-1:WIDTH], |acc_step[2*WIDTH-1:WIDTH]};
                    illegal_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            flags_q     <= '0;
            illegal_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            flags_q     <= flags_d;
            illegal_q   <= illegal_d;
`ifdef ALU_SEQ_MUL_EN
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            count_q     <= count_d;
`endif
        end
    end

    assign outValid = out_valid_q;
    assign dataOut  = data_q;
    assign flags    = flags_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed spot checks plus randomized traffic with random backpressure,
// scored against an arithmetic reference model; honours ALU_SEQ_MUL_EN like the design.
module tb_alu_seq;
    localparam int W = 32;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [4:0]    func;
    logic [W-1:0]  dataIn1;
    logic [W-1:0]  dataIn2;
    logic          inValid;
    logic          inReady;
    logic [W-1:0]  dataOut;
    logic [3:0]    flags;
    logic          illegal;
    logic          outValid;
    logic          outReady;
    logic          busy;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .func     (func),
        .dataIn1  (dataIn1),
        .dataIn2  (dataIn2),
        .inValid  (inValid),
        .inReady  (inReady),
        .dataOut  (dataOut),
        .flags    (flags),
        .illegal  (illegal),
        .outValid (outValid),
        .outReady (outReady),
        .busy     (busy)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  f;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          rnd = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] data_prev;
    logic [3:0]  flags_prev;
    logic        ill_prev;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic out_of_range(input longint x);
        return (x > SMAX) || (x < SMIN);
    endfunction

    // Reference: results from plain integer arithmetic on the operation definitions.
    function automatic exp_t ref_model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        longint      sa;
        longint      sb;
        logic [63:0] u;
        logic [31:0] diff;
        int          sh;
        logic        c;
        logic        v;
        logic        is_cmp;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        diff = a - b;
        c = 1'b0;
        v = 1'b0;
        is_cmp = 1'b0;
        r.d = '0;
        r.ill = 1'b0;
        case (f)
            5'b00000: begin
                u = 64'(a) + 64'(b);
                r.d = u[31:0];
                c = u[32];
                v = out_of_range(sa + sb);
            end
            5'b00001, 5'b00010: begin
                c = (a >= b);
                v = out_of_range(sa - sb);
                is_cmp = (f == 5'b00010);
                r.d = is_cmp ? ((sa < sb) ? 32'd1 : 32'd0) : diff;
            end
`ifdef ALU_SEQ_MUL_EN
            5'b00011: begin
                u = 64'(a) * 64'(b);
                r.d = u[31:0];
                c = (u[63:32] != 0);
                v = c;
            end
`endif
            5'b00100: r.d = a & b;
            5'b00101: r.d = a | b;
            5'b00110: r.d = a ^ b;
            5'b01100: r.d = ~(a & b);
            5'b01101: r.d = ~(a | b);
            5'b01110: r.d = ~(a ^ b);
            5'b01000: r.d = a << sh;
            5'b01001: r.d = a >> sh;
            5'b01010: r.d = (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0);
            5'b01011: r.d = b & 32'hFFFF0000;
            default:  r.ill = 1'b1;
        endcase
        if (is_cmp) r.f = {diff[31], diff == 0, c, v};
        else        r.f = {r.d[31], r.d == 0, c, v};
        if (r.ill) r.f = '0;
        return r;
    endfunction

    function automatic logic [4:0] pick_func();
        int k;
        int idx;
        k = $urandom_range(0, 99);
        if (k < 5)  return 5'b00011;
        if (k < 12) return 5'($urandom_range(15, 31));
        idx = $urandom_range(0, 12);
        if (idx < 3) return 5'(idx);
        if (idx < 6) return 5'(idx + 1);
        return 5'(idx + 2);
    endfunction

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: one entry per accept, popped in order on each transfer out.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset_n) begin
            hold_prev <= 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_data", dataOut, data_prev);
                check("hold_flags", flags, flags_prev);
                check("hold_illegal", illegal, ill_prev);
                check("hold_valid", outValid, 1);
            end
            if (outValid && outReady) begin
                check("out_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_data", dataOut, e.d);
                    check("sb_flags", flags, e.f);
                    check("sb_illegal", illegal, e.ill);
                end
            end
            if (inValid && inReady) exp_q.push_back(ref_model(func, dataIn1, dataIn2));
            hold_prev  <= outValid && !outReady;
            data_prev  <= dataOut;
            flags_prev <= flags;
            ill_prev   <= illegal;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) outReady = ($urandom_range(0, 9) < 7);
    endtask

    task automatic drive_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        func = f;
        dataIn1 = a;
        dataIn2 = b;
        inValid = 1'b1;
        @(negedge clk);
        while (!inReady && guard < 200) begin
            tick();
            @(negedge clk);
            guard++;
        end
        check("accept_in_time", 64'(guard < 200), 1);
        tick();
        inValid = 1'b0;
    endtask

    task automatic dir_op(input string tag, input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input logic [3:0] ef, input logic ei, input int elat);
        int n;
        drive_op(f, a, b);
        n = 1;
        while (!outValid && n < 100) begin
            check({tag, "_busy"}, busy, 1);
            check({tag, "_inready"}, inReady, 0);
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, elat);
        check({tag, "_data"}, dataOut, ed);
        check({tag, "_flags"}, flags, ef);
        check({tag, "_illegal"}, illegal, ei);
    endtask

    initial begin
        logic [31:0] a1, b1, a2, b2, a3, b3;
        int g;
        reset_n  = 1'b0;
        inValid  = 1'b0;
        func     = '0;
        dataIn1  = '0;
        dataIn2  = '0;
        outReady = 1'b1;
        #12;
        check("rst_data", dataOut, 0);
        check("rst_flags", flags, 0);
        check("rst_illegal", illegal, 0);
        check("rst_valid", outValid, 0);
        check("rst_busy", busy, 0);
        check("rst_inready", inReady, 1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        dir_op("add_wrap", 5'b00000, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0110, 1'b0, 1);
        dir_op("cmp_lt", 5'b00010, 32'd5, 32'd7, 32'd1, 4'b1000, 1'b0, 1);
        dir_op("sub_ovf", 5'b00001, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0011, 1'b0, 1);
        dir_op("sra", 5'b01010, 32'h80000000, 32'd4, 32'hF8000000, 4'b1000, 1'b0, 1);
        dir_op("mvhi", 5'b01011, 32'hDEADBEEF, 32'h12345678, 32'h12340000, 4'b0000, 1'b0, 1);
        dir_op("sll", 5'b01000, 32'h1, 32'd31, 32'h80000000, 4'b1000, 1'b0, 1);
        dir_op("illegal_1f", 5'b11111, 32'h1234, 32'h5678, 32'h0, 4'b0000, 1'b1, 1);
`ifdef ALU_SEQ_MUL_EN
        dir_op("mul_big", 5'b00011, 32'h00010000, 32'h00010000, 32'h0, 4'b0111, 1'b0, W + 1);
        dir_op("mul_small", 5'b00011, 32'd3, 32'd5, 32'd15, 4'b0000, 1'b0, W + 1);
`else
        dir_op("mul_absent", 5'b00011, 32'd3, 32'd5, 32'h0, 4'b0000, 1'b1, 1);
`endif

        // Backpressure: first XOR result must sit still while the second waits.
        @(posedge clk);
        #1;
        outReady = 1'b0;
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = $urandom;
        a3 = $urandom; b3 = $urandom;
        drive_op(5'b00110, a1, b1);
        func = 5'b00110; dataIn1 = a2; dataIn2 = b2; inValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_inready", inReady, 0);
            check("bp_valid", outValid, 1);
            check("bp_data", dataOut, a1 ^ b1);
            @(posedge clk);
            #1;
        end
        outReady = 1'b1;
        drive_op(5'b00110, a2, b2);
        check("bp_second", dataOut, a2 ^ b2);
        drive_op(5'b00110, a3, b3);
        check("bp_third", dataOut, a3 ^ b3);
        check("bp_third_valid", outValid, 1);
        @(posedge clk);
        #1;

        // Reset with work in flight: nothing may emerge afterwards.
`ifdef ALU_SEQ_MUL_EN
        drive_op(5'b00011, $urandom, $urandom);
        repeat (9) @(posedge clk);
        #2;
        check("pre_rst_busy", busy, 1);
`else
        outReady = 1'b0;
        drive_op(5'b00000, $urandom, $urandom);
        #2;
        check("pre_rst_valid", outValid, 1);
`endif
        reset_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_valid", outValid, 0);
        check("async_rst_inready", inReady, 1);
        exp_q.delete();
        outReady = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_quiet", outValid, 0);
        end

        // Randomized traffic under random backpressure.
        rnd = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive_op(pick_func(), pick_opnd(), pick_opnd());
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd = 1'b0;
        outReady = 1'b1;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
